db_tupu_ram_ctrl: RTL
=====================

DB_TUPU_RAM_CTRL -- requirements
Module: db_tupu_ram_ctrl

Interface
REQ-001 SHALL have parameter ADR_W, default 6, RAM address width (64 entries).
REQ-002 SHALL have parameter DAT_W, default 32, RAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clr_i  input  1  single-cycle pulse; restart clear sweep.
REQ-006 SHALL have port busy_o  output  1  high while clear sweep in progress.
REQ-007 SHALL have port wr_req_i  input  1  write request; held until wr_ack_o.
REQ-008 SHALL have port wr_adr_i  input  ADR_W  write address; stable while wr_req_i is high.
REQ-009 SHALL have port wr_dat_i  input  DAT_W  write data; stable while wr_req_i is high.
REQ-010 SHALL have port wr_ack_o  output  1  write granted this cycle.
REQ-011 SHALL have port rd_req_i  input  1  read request; held until rd_ack_o.
REQ-012 SHALL have port rd_adr_i  input  ADR_W  read address; stable while rd_req_i is high.
REQ-013 SHALL have port rd_ack_o  output  1  read granted this cycle.
REQ-014 SHALL have port rd_vld_o  output  1  rd_dat_o valid this cycle.
REQ-015 SHALL have port rd_dat_o  output  DAT_W  read data, passed through from ram_rd_dat_i.
REQ-016 SHALL have ports ram_cen_o, ram_wen_o (output 1, low active), ram_adr_o (output ADR_W), ram_wr_dat_o (output DAT_W), ram_rd_dat_i (input DAT_W); these connect to the single-port 64x32 RAM with 1-cycle read latency.

Function
REQ-017 SHALL implement FSM states INIT (clear sweep) and RUN.
REQ-018 INIT SHALL issue 64 writes of zero, addresses 0..63 in ascending order, one per cycle; after the command for address 63 is issued, next state SHALL be RUN.
REQ-019 busy_o SHALL be high in INIT and low in RUN.
REQ-020 In INIT, wr_ack_o and rd_ack_o SHALL be 0.
REQ-021 clr_i in RUN SHALL enter INIT next cycle with counter 0.
REQ-022 clr_i in INIT SHALL reset the counter to 0, so the sweep restarts.
REQ-023 In RUN, at most one of wr_ack_o/rd_ack_o SHALL be high per cycle; each ack is combinational from its request and the current state.
REQ-024 All ram_* outputs SHALL be registered.
REQ-025 A grant in cycle T SHALL drive the RAM command in cycle T+1.
REQ-026 For a read granted in cycle T, rd_vld_o SHALL be high exactly in cycle T+2.
REQ-027 Back-to-back grants SHALL be sustained at one access per cycle, with no bubbles.
REQ-028 Idle cycles SHALL drive ram_cen_o=1 and ram_wen_o=1; ram_adr_o and ram_wr_dat_o hold their last values.
REQ-029 A read already in flight when clr_i arrives SHALL still produce its rd_vld_o pulse.
REQ-030 Address counter SHALL be ADR_W bits and SHALL NOT wrap within a sweep.

Reset
REQ-031 rst_n low SHALL asynchronously force: state INIT, counter 0, ram_cen_o=1, ram_wen_o=1, ram_adr_o=0, ram_wr_dat_o=0, rd_vld_o=0, read pipeline cleared, RR pointer to write.
REQ-032 wr_ack_o and rd_ack_o SHALL be 0 while rst_n is low, because state is INIT.
REQ-033 The first sweep command SHALL appear in the first cycle after rst_n deasserts.

Configuration
REQ-034 Macro DB_TUPU_ARB_RR_EN SHALL select the arbitration policy for simultaneous wr_req_i and rd_req_i.
REQ-035 Without DB_TUPU_ARB_RR_EN, the write SHALL always win a simultaneous request.
REQ-036 With DB_TUPU_ARB_RR_EN, the requester not granted most recently SHALL win a simultaneous request; the pointer updates on every grant.

Verification
REQ-037 Release reset -> RAM commands wen=0, adr 0..63, data 0, in cycles 1..64; busy_o falls in cycle 65; no acks before then.
REQ-038 RUN: write adr 5 = 0xDEADBEEF, then read adr 5 -> rd_vld_o 2 cycles after rd_ack_o with rd_dat_o=0xDEADBEEF.
REQ-039 Both requests held 4 cycles: without macro, grant order W,W,W,W while read stalls; with macro, grant order alternates W,R,W,R.
REQ-040 Read ack at T, clr_i at T+1 -> rd_vld_o at T+2, then a 64-cycle sweep, and a subsequent read of adr 5 returns 0.
REQ-041 clr_i at sweep address 30 -> sweep restarts at 0; busy_o stays high 64 more cycles.
REQ-042 rst_n low mid-read -> rd_vld_o never asserts; all outputs take reset values immediately.

Source files
------------

// File: rtl/db_tupu_ram_ctrl.sv
// db_tupu_ram_ctrl: front-end for a single-port RAM with 1-cycle read latency.
// After reset or clr_i it sweeps every address with zero (busy_o high), then
// arbitrates write/read requests into registered RAM commands.
// Optional macro DB_TUPU_ARB_RR_EN: round-robin arbitration between a
// simultaneous write and read; without it the write always wins.
module db_tupu_ram_ctrl #(
  parameter int ADR_W = 6,
  parameter int DAT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  output logic             busy_o,
  input  logic             wr_req_i,
  input  logic [ADR_W-1:0] wr_adr_i,
  input  logic [DAT_W-1:0] wr_dat_i,
  output logic             wr_ack_o,
  input  logic             rd_req_i,
  input  logic [ADR_W-1:0] rd_adr_i,
  output logic             rd_ack_o,
  output logic             rd_vld_o,
  output logic [DAT_W-1:0] rd_dat_o,
  output logic             ram_cen_o,
  output logic             ram_wen_o,
  output logic [ADR_W-1:0] ram_adr_o,
  output logic [DAT_W-1:0] ram_wr_dat_o,
  input  logic [DAT_W-1:0] ram_rd_dat_i
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [ADR_W-1:0] cnt_q, cnt_d;
  // Set once the last sweep address has been issued; INIT then lingers one
  // more cycle so busy_o covers the cycle the final command is on the pins.
  logic             done_q, done_d;
  logic             sweep_cmd;
  logic             wr_pri;
  logic             rd_p1_q;

`ifdef DB_TUPU_ARB_RR_EN
  logic pref_wr_q;

  // Round-robin pointer: the requester not granted last gets priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pref_wr_q <= 1'b1;
    else if (wr_ack_o) pref_wr_q <= 1'b0;
    else if (rd_ack_o) pref_wr_q <= 1'b1;
  end

  assign wr_pri = pref_wr_q;
`else
  assign wr_pri = 1'b1;
`endif

  // State, sweep counter and sweep-done flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state, sweep sequencing and combinational grants.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    sweep_cmd = 1'b0;
    wr_ack_o  = 1'b0;
    rd_ack_o  = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (clr_i) begin
          cnt_d  = '0;
          done_d = 1'b0;
        end else if (done_q) begin
          state_d = ST_RUN;
          done_d  = 1'b0;
        end else begin
          sweep_cmd = 1'b1;
          if (cnt_q == '1) done_d = 1'b1;
          else             cnt_d  = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        wr_ack_o = wr_req_i & (~rd_req_i | wr_pri);
        rd_ack_o = rd_req_i & (~wr_req_i | ~wr_pri);
        if (clr_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign busy_o = (state_q == ST_INIT);

  // Registered RAM command: sweep write, granted write, granted read or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cen_o    <= 1'b1;
      ram_wen_o    <= 1'b1;
      ram_adr_o    <= '0;
      ram_wr_dat_o <= '0;
    end else if (sweep_cmd) begin
      ram_cen_o    <= 1'b0;
      ram_wen_o    <= 1'b0;
      ram_adr_o    <= cnt_q;
      ram_wr_dat_o <= '0;
    end else if (wr_ack_o) begin
      ram_cen_o    <= 1'b0;
      ram_wen_o    <= 1'b0;
      ram_adr_o    <= wr_adr_i;
      ram_wr_dat_o <= wr_dat_i;
    end else if (rd_ack_o) begin
      ram_cen_o    <= 1'b0;
      ram_wen_o    <= 1'b1;
      ram_adr_o    <= rd_adr_i;
    end else begin
      ram_cen_o    <= 1'b1;
      ram_wen_o    <= 1'b1;
    end
  end

  // Read pipeline: grant -> RAM command -> data valid; clr_i does not flush it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1_q  <= 1'b0;
      rd_vld_o <= 1'b0;
    end else begin
      rd_p1_q  <= rd_ack_o;
      rd_vld_o <= rd_p1_q;
    end
  end

  assign rd_dat_o = ram_rd_dat_i;

endmodule
